// File: rtl/dsp_boot_ctrl_pkg.sv
// Shared definitions for the DSP boot/run sequencer: widths, boolean
// constants and the sequencer state encoding.
package dsp_boot_ctrl_pkg;

    localparam int SRAM_ADDR_LEN = 15;
    localparam int REG_WORD_LEN  = 16;
    localparam int RUN_LEN_W     = 24;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [2:0] {
        BOOT_IDLE   = 3'd0,
        BOOT_LOAD   = 3'd1,
        BOOT_SETTLE = 3'd2,
        BOOT_RUN    = 3'd3,
        BOOT_DONE   = 3'd4
    } boot_state_t;

endpackage

// File: rtl/dsp_boot_ctrl_run_timer.sv
// Loadable up-counter with a terminal-count flag. Used to time the DSP run
// phase and intended for reuse as a watchdog timer.
module boot_run_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term_val,
    output logic         tc
);

    logic [W-1:0] count_q;

    // Counter: load has priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en) begin
            count_q <= count_q + W'(1);
        end
    end

    assign tc = (count_q == term_val);

endmodule

// File: rtl/dsp_boot_ctrl.sv
// Boot and run sequencer for the DSP core: streams a block of words into
// data memory bank I, releases the DSP reset for a programmed number of
// cycles, then puts the DSP back in reset and pulses done.
//
// Input handshake: a word is transferred on a rising clk edge when
// in_valid && in_ready are both high in the cycle before it. in_ready is
// high only in LOAD and is forced low while abort is high, so an aborted
// cycle never transfers. in_data must be stable while in_valid is high.
module dsp_boot_ctrl
    import dsp_boot_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_LEN,
    parameter int DATA_W = REG_WORD_LEN,
    parameter int RUN_W  = RUN_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] load_len,
    input  logic [RUN_W-1:0]  run_len,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              write_en_1,
    output logic [ADDR_W-1:0] write_addr_1,
    output logic [DATA_W-1:0] write_data_1,
    output logic              dsp_rst,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] words_loaded,
    output boot_state_t       state_dbg
);

    boot_state_t       state_q;
    boot_state_t       state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] load_len_q;
    logic [RUN_W-1:0]  run_len_q;
    logic              xfer;
    logic              last_word;
    logic              run_tc;
    logic              run_end;
    logic              busy_d;
    logic              dsp_rst_d;
    logic              done_d;

    assign in_ready  = (state_q == BOOT_LOAD) && !abort;
    assign xfer      = in_valid && in_ready;
    assign last_word = ((words_loaded + ADDR_W'(1)) == load_len_q);
    assign run_end   = run_tc && (run_len_q != '0);
    assign state_dbg = state_q;

    // Run-phase timer: cleared in SETTLE so it reads 0 in the first RUN cycle.
    boot_run_timer #(
        .W(RUN_W)
    ) u_run_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == BOOT_SETTLE),
        .en       (state_q == BOOT_RUN),
        .load_val ('0),
        .term_val (run_len_q - RUN_W'(1)),
        .tc       (run_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over every other exit of LOAD/SETTLE/RUN.
    // DONE is already the end of the sequence, so it always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT_IDLE: begin
                if (start) begin
                    state_d = (load_len == '0) ? BOOT_SETTLE : BOOT_LOAD;
                end
            end
            BOOT_LOAD: begin
                if (abort) begin
                    state_d = BOOT_DONE;
                end else if (xfer && last_word) begin
                    state_d = BOOT_SETTLE;
                end
            end
            BOOT_SETTLE: begin
                state_d = abort ? BOOT_DONE : BOOT_RUN;
            end
            BOOT_RUN: begin
                if (abort || run_end) begin
                    state_d = BOOT_DONE;
                end
            end
            BOOT_DONE: begin
                state_d = BOOT_IDLE;
            end
            default: begin
                state_d = BOOT_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up
    // with the state they describe.
    always_comb begin
        busy_d    = (state_d != BOOT_IDLE);
        dsp_rst_d = (state_d != BOOT_RUN);
        done_d    = (state_d == BOOT_DONE);
    end

    // Output registers, sequence parameter latches and the bank I write path.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= FALSE;
            dsp_rst      <= TRUE;
            done         <= FALSE;
            write_en_1   <= FALSE;
            write_addr_1 <= '0;
            write_data_1 <= '0;
            words_loaded <= '0;
            base_q       <= '0;
            load_len_q   <= '0;
            run_len_q    <= '0;
        end else begin
            busy       <= busy_d;
            dsp_rst    <= dsp_rst_d;
            done       <= done_d;
            write_en_1 <= xfer;
            if (state_q == BOOT_IDLE && start) begin
                base_q       <= base_addr;
                load_len_q   <= load_len;
                run_len_q    <= run_len;
                words_loaded <= '0;
            end
            if (xfer) begin
                // Address arithmetic wraps naturally at 2^ADDR_W.
                write_addr_1 <= base_q + words_loaded;
                write_data_1 <= in_data;
                words_loaded <= words_loaded + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dsp_boot_ctrl.sv
// Bench for dsp_boot_ctrl: reset check, a table of load+run sequences,
// randomized sequences, and hand-written reset-in-RUN sequence.
module tb_dsp_boot_ctrl;
  import dsp_boot_ctrl_pkg::*;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int RUN_W  = 24;
  localparam int BUDGET = 1000;

  typedef struct {
    int base;
    int load_len;
    int run_len;
    int gap;          // 0 always valid, 1 toggling valid, 2 random valid
    int abort_word;   // abort once this many words accepted (-1 never)
    int abort_run;    // abort after this many run cycles (-1 never)
    int start_in_run; // pulse a stray start during RUN
    int data_seed;
    int exp_words;
    int exp_run;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] load_len;
  logic [RUN_W-1:0]  run_len;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              write_en_1;
  logic [ADDR_W-1:0] write_addr_1;
  logic [DATA_W-1:0] write_data_1;
  logic              dsp_rst;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] words_loaded;
  boot_state_t       state_dbg;

  dsp_boot_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .load_len     (load_len),
    .run_len      (run_len),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .write_en_1   (write_en_1),
    .write_addr_1 (write_addr_1),
    .write_data_1 (write_data_1),
    .dsp_rst      (dsp_rst),
    .busy         (busy),
    .done         (done),
    .words_loaded (words_loaded),
    .state_dbg    (state_dbg)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_write_en"}, 32'(write_en_1), 32'd0);
    check({tag, "_write_addr"}, 32'(write_addr_1), 32'd0);
    check({tag, "_write_data"}, 32'(write_data_1), 32'd0);
    check({tag, "_dsp_rst"}, 32'(dsp_rst), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  // driver + monitor for one complete start..done sequence
  task automatic run_seq(input vec_t v);
    int accepted, run_cnt, done_cnt, wr_cnt, cyc;
    bit aborted, finished, done_seen, extra_sent;
    logic last_dsp_rst;
    logic [ADDR_W-1:0] exp_addr;
    logic [ADDR_W+DATA_W-1:0] got, want;
    exp_q.delete();
    accepted = 0; run_cnt = 0; done_cnt = 0; wr_cnt = 0; cyc = 0;
    aborted = 0; finished = 0; done_seen = 0; extra_sent = 0;
    last_dsp_rst = 1'b1;
    while (!finished && cyc < BUDGET) begin
      start = (cyc == 0);
      if (cyc == 0) begin
        base_addr = ADDR_W'(v.base);
        load_len  = ADDR_W'(v.load_len);
        run_len   = RUN_W'(v.run_len);
      end else begin
        // parameters must have been latched; scramble them
        base_addr = ADDR_W'($urandom);
        load_len  = ADDR_W'($urandom_range(0, 20));
        run_len   = RUN_W'($urandom_range(0, 5));
      end
      if (v.start_in_run != 0 && !extra_sent && run_cnt == 2) begin
        start = 1'b1;
        extra_sent = 1;
      end
      abort = 1'b0;
      if (!aborted && v.abort_word >= 0 && cyc > 0 && accepted == v.abort_word) begin
        abort = 1'b1;
        aborted = 1;
      end
      if (!aborted && v.abort_run >= 0 && !last_dsp_rst && run_cnt == v.abort_run) begin
        abort = 1'b1;
        aborted = 1;
      end
      case (v.gap)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2) == 1;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? DATA_W'(v.data_seed + accepted) : DATA_W'($urandom);
      #1;
      if (abort) check("ready_during_abort", 32'(in_ready), 32'd0);
      if (in_valid && in_ready) begin
        exp_addr = ADDR_W'(v.base) + ADDR_W'(accepted);
        exp_q.push_back({exp_addr, in_data});
        accepted++;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (write_en_1) begin
        wr_cnt++;
        check("write_while_running", 32'(dsp_rst), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h/%0h expected=none", write_addr_1, write_data_1);
        end else begin
          want = exp_q.pop_front();
          got  = {write_addr_1, write_data_1};
          check("write_addr_data", 32'(got), 32'(want));
        end
      end
      if (!dsp_rst) run_cnt++;
      if (done_seen) begin
        check("done_single_pulse", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("dsp_rst_after_done", 32'(dsp_rst), 32'd1);
        finished = 1;
      end else if (done) begin
        done_cnt++;
        done_seen = 1;
        check("dsp_rst_in_done", 32'(dsp_rst), 32'd1);
      end
      last_dsp_rst = dsp_rst;
      cyc++;
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL sequence_timeout actual=%0d cycles expected=done pulse", cyc);
    end
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check("write_count", 32'(wr_cnt), 32'(v.exp_words));
    check("run_cycles", 32'(run_cnt), 32'(v.exp_run));
    check("done_count", 32'(done_cnt), 32'd1);
    check("words_loaded", 32'(words_loaded), 32'(v.exp_words));
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    // vector table: base, load, run, gap, abort_word, abort_run, stray start, seed, exp words, exp run
    vecs[0] = '{0,       4, 10, 0, -1, -1, 0, 25,  4, 10}; // basic load+run
    vecs[1] = '{'h100,   4,  5, 1, -1, -1, 0, 'h40, 4,  5}; // toggling valid
    vecs[2] = '{'h7FFE,  4,  3, 0, -1, -1, 0, 'h900, 4, 3}; // address wrap
    vecs[3] = '{0,       0,  3, 0, -1, -1, 0, 7,   0,  3}; // skip load
    vecs[4] = '{'h10,    3,  0, 0, -1,  6, 0, 'h11, 3,  6}; // run until abort
    vecs[5] = '{0,       8,  5, 0,  2, -1, 0, 'h200, 2, 0}; // abort mid-load
    vecs[6] = '{'h20,    2,  8, 0, -1, -1, 1, 'h300, 2, 8}; // stray start in RUN
    vecs[7] = '{'h7FF0, 40,  7, 2, -1, -1, 0, 'hA00, 40, 7}; // random gaps, wrap

    start = 0; base_addr = '0; load_len = '0; run_len = '0;
    abort = 0; in_valid = 0; in_data = '0;

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_seq(vecs[i]);

    // randomized sequences, expectations from the sequencing rules
    for (int i = 0; i < 12; i++) begin
      int r;
      rv.base = int'($urandom_range(0, 32767));
      rv.load_len = int'($urandom_range(0, 12));
      rv.run_len = int'($urandom_range(0, 15));
      rv.gap = 2;
      rv.abort_word = -1;
      rv.abort_run = -1;
      rv.start_in_run = int'($urandom_range(0, 1));
      rv.data_seed = int'($urandom_range(0, 65535));
      r = int'($urandom_range(0, 3));
      if (r == 0 && rv.load_len >= 2) rv.abort_word = int'($urandom_range(1, rv.load_len - 1));
      else if (rv.run_len == 0) rv.abort_run = int'($urandom_range(1, 6));
      else if (r == 1 && rv.run_len >= 2) rv.abort_run = int'($urandom_range(1, rv.run_len - 1));
      rv.exp_words = (rv.abort_word >= 0) ? rv.abort_word : rv.load_len;
      rv.exp_run = (rv.abort_word >= 0) ? 0 : (rv.abort_run >= 0) ? rv.abort_run : rv.run_len;
      run_seq(rv);
    end

    // reset asserted while the DSP is running
    begin
      int low_cnt = 0;
      int cyc = 0;
      start = 1'b1; base_addr = 15'h5; load_len = 15'd2; run_len = 24'd20;
      in_valid = 1'b1; in_data = 16'h1234;
      @(posedge clk);
      #1;
      start = 1'b0;
      while (low_cnt < 3 && cyc < 100) begin
        @(posedge clk);
        #1;
        if (!dsp_rst) low_cnt++;
        cyc++;
      end
      check("reached_run_before_rst", 32'(low_cnt), 32'd3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs("rst_in_run");
      rst = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("stay_idle_after_rst", 32'(busy), 32'd0);
    end

    // controller must still work after the mid-run reset
    run_seq(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
